// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative signed multiply/divide engine.
// One result bit per cycle in RUN; signs are stripped on entry and reapplied in FIX.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       move_hi_lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_out
);

    localparam logic [1:0] MOVE_HIGH = 2'b01;
    localparam logic [1:0] MOVE_LOW  = 2'b10;
    localparam int         CW        = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZDIV} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     mag_a, mag_b;
    logic               sign_a, sign_b, is_div;

    logic [WIDTH:0]     ext_a, ext_b, abs_a, abs_b;
    logic [WIDTH:0]     mult_sum, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               last_iter;

    // Magnitudes are formed in WIDTH+1 bits so the most negative operand stays exact.
    always_comb begin
        ext_a     = {op_a[WIDTH-1], op_a};
        ext_b     = {op_b[WIDTH-1], op_b};
        abs_a     = ext_a[WIDTH] ? -ext_a : ext_a;
        abs_b     = ext_b[WIDTH] ? -ext_b : ext_b;
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? mag_a : '0);
        div_diff  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - mag_b;
        prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_next = RUN;
                else if (start_div) state_next = (op_b == '0) ? ZDIV : RUN;
            end
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            ZDIV:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            is_div      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        sign_a <= op_a[WIDTH-1];
                        sign_b <= op_b[WIDTH-1];
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        is_div <= !start_mult;
                        cnt    <= '0;
                        acc    <= start_mult ? {{WIDTH{1'b0}}, abs_b[WIDTH-1:0]}
                                             : {{WIDTH{1'b0}}, abs_a[WIDTH-1:0]};
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        // Restoring step: keep the shifted remainder when the trial subtract goes negative.
                        if (div_diff[WIDTH])
                            acc <= {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
                        else
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {mult_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                ZDIV: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start_mult | start_div | (move_hi_lo != 2'b00));

    always_comb begin
        hilo_out = '0;
        if (move_hi_lo == MOVE_HIGH)     hilo_out = hi;
        else if (move_hi_lo == MOVE_LOW) hilo_out = lo;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: latency, signed results, div-by-zero,
// stall behaviour, MFHI/MFLO forwarding and asynchronous reset mid-operation.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic [1:0]  move_hi_lo;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo, hilo_out;

    int tests  = 0;
    int errors = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_mult(start_mult), .start_div(start_div),
        .op_a(op_a), .op_b(op_b), .move_hi_lo(move_hi_lo),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one start, then count edges until done (bounded) and check latency/flags.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic dbz);
        int  n;
        bit  seen;
        start_mult = m; start_div = d; op_a = a; op_b = b;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_dbz"}, div_by_zero, dbz);
        check({tag, "_busy_off"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n, stall_bad;
        bit seen;
        rst_n = 1'b0; start_mult = 1'b0; start_div = 1'b0;
        op_a = '0; op_b = '0; move_hi_lo = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 1: 7 * -3
        run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 0);
        check("mul_7_m3_hi", hi, 64'hFFFF_FFFF);
        check("mul_7_m3_lo", lo, 64'hFFFF_FFEB);
        move_hi_lo = 2'b01; #1;
        check("mfhi", hilo_out, 64'hFFFF_FFFF);
        move_hi_lo = 2'b00; #1;
        check("move_none", hilo_out, 0);

        // 2: signed division rounding toward zero
        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 33, 0);
        check("div_m7_2_lo", lo, 64'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 64'hFFFF_FFFF);
        run_op("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 33, 0);
        check("div_7_m2_lo", lo, 64'hFFFF_FFFD);
        check("div_7_m2_hi", hi, 64'h0000_0001);

        // 3: seed HI=0x1111 LO=0x2222, then divide by zero
        run_op("seed", 0, 1, 32'h2222_1111, 32'h0001_0000, 33, 0);
        check("seed_hi", hi, 64'h1111);
        check("seed_lo", lo, 64'h2222);
        run_op("div_zero", 0, 1, 32'd5, 32'd0, 1, 1);
        check("div_zero_hi", hi, 64'h1111);
        check("div_zero_lo", lo, 64'h2222);

        // 4: overflow corners
        run_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0);
        check("div_ovf_lo", lo, 64'h8000_0000);
        check("div_ovf_hi", hi, 64'h0);
        run_op("mul_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, 0);
        check("mul_min_hi", hi, 64'h4000_0000);
        check("mul_min_lo", lo, 64'h0);

        // 5a: MFLO presented 3 cycles into mult 6*7 stalls until done
        start_mult = 1'b1; op_a = 32'd6; op_b = 32'd7;
        @(posedge clk); #1;
        start_mult = 1'b0;
        n = 0; seen = 0; stall_bad = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) begin move_hi_lo = 2'b10; #1; end
            if (done) seen = 1;
            else if (n >= 3 && !stall) stall_bad++;
        end
        check("mflo_latency", n, 33);
        check("mflo_stall_hold", stall_bad, 0);
        check("mflo_done_stall", stall, 0);
        check("mflo_value", hilo_out, 64'h2A);
        move_hi_lo = 2'b00;
        @(posedge clk); #1;

        // 5b: start_div while busy stalls and does not restart the mult
        start_mult = 1'b1; op_a = 32'd5; op_b = 32'd9;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd3; #1;
        check("busy_div_stall", stall, 1);
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) start_div = 1'b0;
            if (done) seen = 1;
        end
        check("norestart_latency", n, 33);
        check("norestart_lo", lo, 64'd45);
        check("norestart_hi", hi, 64'd0);
        @(posedge clk); #1;

        // Move and start in the same IDLE cycle: old value returned, start proceeds
        move_hi_lo = 2'b10; start_mult = 1'b1; op_a = 32'd3; op_b = 32'd4; #1;
        check("move_start_old", hilo_out, 64'd45);
        check("move_start_stall", stall, 0);
        run_op("mul_3_4", 1, 0, 32'd3, 32'd4, 33, 0);
        move_hi_lo = 2'b00;
        check("mul_3_4_lo", lo, 64'd12);

        // 6: asynchronous reset at edge 10 of a division
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start_div = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_op("mul_2_3", 1, 0, 32'd2, 32'd3, 33, 0);
        check("mul_2_3_lo", lo, 64'd6);
        check("mul_2_3_hi", hi, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
